// File: rtl/shreg_ctrl_pkg.sv
// ============================================================================
// shreg_ctrl_pkg : state encoding and helper function for shift_reg_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package shreg_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_LOAD  = S_LOAD,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_t;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_reg_ctrl_if.sv
// ============================================================================
// shift_reg_ctrl_if : word-source handshake and shift-register control bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface shift_reg_ctrl_if #(
    parameter int WIDTH = 4
);
    localparam int IDX_W = $clog2(WIDTH + 2);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             abort;
    logic             sr_load;
    logic [WIDTH-1:0] sr_data;
    logic             sr_shift;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] bit_idx;
    logic             par_bit;

    modport master (
        output in_valid, in_data, abort,
        input  in_ready, sr_load, sr_data, sr_shift, busy, done, bit_idx, par_bit
    );

    modport slave (
        input  in_valid, in_data, abort,
        output in_ready, sr_load, sr_data, sr_shift, busy, done, bit_idx, par_bit
    );

endinterface

`default_nettype wire

// File: rtl/shreg_ctrl_prescaler.sv
// ============================================================================
// shreg_ctrl_prescaler : DIV-modulo counter with sync clear, 1-cycle tick out
// Revision: 1.0
// ============================================================================
`default_nettype none

module shreg_ctrl_prescaler
    import shreg_ctrl_pkg::*;
#(
    parameter int DIV = 1
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  clear,
    output logic tick
);
    localparam int               c_cnt_w = cnt_width(DIV);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = !clear && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/shift_reg_ctrl.sv
// ============================================================================
// shift_reg_ctrl : load/shift sequencer for a parallel-load shift register.
// Optional even-parity slot enabled by defining SHREG_CTRL_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_reg_ctrl
    import shreg_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  wire              clk,
    input  wire              reset,
    shift_reg_ctrl_if.slave  bus
);
`ifdef SHREG_CTRL_PARITY_EN
    localparam int c_nshift = WIDTH + 1;
`else
    localparam int c_nshift = WIDTH;
`endif
    localparam int                 c_idx_w    = $clog2(WIDTH + 2);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nshift);
    localparam logic [c_idx_w-1:0] c_par_idx  = c_idx_w'(c_nshift - 1);

    state_t r_state;
    logic   w_tick;
    logic   w_clear;
    logic   w_par;
    logic   w_accept;

    assign w_clear  = (r_state != ST_SHIFT);
    // in_ready is only ever set in IDLE/DONE, so it alone qualifies the accept.
    assign w_accept = bus.in_valid && bus.in_ready;

`ifdef SHREG_CTRL_PARITY_EN
    assign w_par = ^bus.sr_data;
`else
    assign w_par = 1'b0;
`endif

    shreg_ctrl_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            bus.in_ready <= 1'b0;
            bus.sr_load  <= 1'b0;
            bus.sr_data  <= '0;
            bus.sr_shift <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.bit_idx  <= '0;
            bus.par_bit  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (w_accept) begin
                bus.sr_data  <= bus.in_data;
                bus.sr_load  <= 1'b1;
                bus.in_ready <= 1'b0;
                bus.busy     <= 1'b1;
                r_state      <= ST_LOAD;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        bus.in_ready <= 1'b1;
                    end
                    ST_LOAD, ST_SHIFT: begin
                        if (bus.abort) begin
                            bus.sr_load  <= 1'b0;
                            bus.sr_shift <= 1'b0;
                            bus.par_bit  <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.in_ready <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else if (r_state == ST_LOAD) begin
                            bus.sr_load <= 1'b0;
                            bus.bit_idx <= '0;
                            r_state     <= ST_SHIFT;
                        end else if (bus.bit_idx == c_last_idx) begin
                            bus.sr_shift <= 1'b0;
                            bus.par_bit  <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.done     <= 1'b1;
                            bus.in_ready <= 1'b1;
                            r_state      <= ST_DONE;
                        end else if (w_tick) begin
                            bus.sr_shift <= 1'b1;
                            bus.bit_idx  <= bus.bit_idx + 1'b1;
                            bus.par_bit  <= (bus.bit_idx == c_par_idx) && w_par;
                        end else begin
                            bus.sr_shift <= 1'b0;
                            bus.par_bit  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_ctrl.sv
// ============================================================================
// tb_shift_reg_ctrl : directed, scoreboard-checked bench for shift_reg_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shift_reg_ctrl;

`ifdef SHREG_CTRL_PARITY_EN
    localparam int c_pen = 1;
`else
    localparam int c_pen = 0;
`endif
    localparam int NS = 4 + c_pen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       drv_valid;
    logic [3:0] drv_data;
    logic       drv_abort;
    logic       sel3;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    shift_reg_ctrl_if #(.WIDTH(4)) if1 ();
    shift_reg_ctrl_if #(.WIDTH(4)) if3 ();

    shift_reg_ctrl #(.WIDTH(4), .DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    shift_reg_ctrl #(.WIDTH(4), .DIV(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

    assign if1.in_valid = drv_valid & ~sel3;
    assign if3.in_valid = drv_valid &  sel3;
    assign if1.in_data  = drv_data;
    assign if3.in_data  = drv_data;
    assign if1.abort    = drv_abort & ~sel3;
    assign if3.abort    = drv_abort &  sel3;

    logic       obs_ready, obs_load, obs_shift, obs_busy, obs_done, obs_par;
    logic [3:0] obs_data;
    logic [2:0] obs_idx;
    assign obs_ready = sel3 ? if3.in_ready : if1.in_ready;
    assign obs_load  = sel3 ? if3.sr_load  : if1.sr_load;
    assign obs_shift = sel3 ? if3.sr_shift : if1.sr_shift;
    assign obs_busy  = sel3 ? if3.busy     : if1.busy;
    assign obs_done  = sel3 ? if3.done     : if1.done;
    assign obs_par   = sel3 ? if3.par_bit  : if1.par_bit;
    assign obs_data  = sel3 ? if3.sr_data  : if1.sr_data;
    assign obs_idx   = sel3 ? if3.bit_idx  : if1.bit_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, obs_ready, 0);
        chk({tag, "_load"},  obs_load,  0);
        chk({tag, "_shift"}, obs_shift, 0);
        chk({tag, "_busy"},  obs_busy,  0);
        chk({tag, "_done"},  obs_done,  0);
        chk({tag, "_par"},   obs_par,   0);
        chk({tag, "_data"},  obs_data,  0);
        chk({tag, "_idx"},   obs_idx,   0);
    endtask

    // Offer word d at the current negedge and trace the selected DUT cycle by
    // cycle against the timing model; abort_k>0 aborts during pulse abort_k.
    task automatic run_word(input logic [3:0] d, input int div, input int abort_k,
                            input bit abort_in_idle);
        int         last;
        int         done_c;
        int         npl;
        bit         exp_shift;
        bit         aborted;
        logic [3:0] got;
        last    = 2 + div * NS;
        done_c  = last + 1;
        aborted = 0;
        chk("pre_ready", obs_ready, 1);
        drv_data  = d;
        drv_valid = 1'b1;
        drv_abort = abort_in_idle;
        exp_q.push_back(d);
        for (int c = 1; c <= done_c; c++) begin
            @(negedge clk);
            if (c == 1) begin
                drv_valid = 1'b0;
                drv_abort = 1'b0;
                drv_data  = ~d;
            end
            exp_shift = (c >= 2 + div) && (c <= last) && (((c - 2) % div) == 0);
            npl = (c < 2 + div) ? 0 : ((c - 2) / div);
            if (npl > NS) npl = NS;
            chk("sr_load",  obs_load,  32'(c == 1));
            chk("sr_shift", obs_shift, 32'(exp_shift));
            chk("busy",     obs_busy,  32'(c <= last));
            chk("done",     obs_done,  32'(c == done_c));
            chk("in_ready", obs_ready, 32'(c == done_c));
            chk("par_bit",  obs_par,   (c_pen == 1 && c == last) ? 32'(^d) : 32'd0);
            if (c == 1) begin
                chk("sb_depth", exp_q.size(), 1);
                got = exp_q.pop_front();
                chk("sr_data", obs_data, 32'(got));
            end else begin
                chk("bit_idx", obs_idx, npl);
            end
            if (abort_k > 0 && c == 2 + div * abort_k) begin
                aborted = 1;
                break;
            end
        end
        if (aborted) begin
            drv_abort = 1'b1;
            @(negedge clk);
            drv_abort = 1'b0;
            chk("abort_shift", obs_shift, 0);
            chk("abort_busy",  obs_busy,  0);
            chk("abort_load",  obs_load,  0);
            chk("abort_ready", obs_ready, 1);
            chk("abort_done",  obs_done,  0);
            chk("abort_data",  obs_data,  32'(d));
            repeat (2 * div + 4) begin
                @(negedge clk);
                chk("abort_noshift", obs_shift, 0);
                chk("abort_nodone",  obs_done,  0);
            end
        end
    endtask

    initial begin
        drv_valid = 1'b1;
        drv_data  = 4'b1010;
        drv_abort = 1'b0;
        sel3      = 1'b0;

        // Reset held with a word on offer
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel3 = s[0];
            #1;
            chk_all_zero("rst");
        end
        sel3  = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("rel_ready_pre", obs_ready, 0);
        @(negedge clk);
        chk("rel_ready", obs_ready, 1);
        chk("rel_noload", obs_load, 0);
        chk("rel_busy", obs_busy, 0);
        drv_valid = 1'b0;
        @(negedge clk);

        // Nominal word, then a back-to-back word accepted in the DONE cycle
        run_word(4'b1010, 1, 0, 0);
        run_word(4'b0101, 1, 0, 0);

        // Paced shifting on the DIV=3 instance
        sel3 = 1'b1;
        #1;
        run_word(4'b0110, 3, 0, 0);
        sel3 = 1'b0;
        #1;

        // Abort after the second pulse, then a clean word
        run_word(4'b1100, 1, 2, 0);
        run_word(4'b0001, 1, 0, 0);

        // Abort asserted together with an accept in IDLE is ignored
        @(negedge clk);
        run_word(4'b0011, 1, 0, 1);

        // Asynchronous reset between edges during SHIFT
        @(negedge clk);
        drv_valid = 1'b1;
        drv_data  = 4'b1110;
        @(negedge clk);
        drv_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_areset_shift", obs_shift, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("areset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("areset_rel_ready", obs_ready, 1);
        run_word(4'b0001, 1, 0, 0);

        // Parity slot words (4 pulses, par_bit 0 when the slot is disabled)
        run_word(4'b1011, 1, 0, 0);
        run_word(4'b1001, 1, 0, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
